// File: rtl/delayed_wb_arbiter_pkg.sv
// Shared types and constants for the delayed GPR writeback path.
// Widths here are the defaults; the top re-derives its entry type from its own parameters.
package delayed_wb_arbiter_pkg;

   localparam int GPR_W_DEF  = 5;
   localparam int DATA_W_DEF = 32;
   localparam int WB_DEPTH   = 4;

   typedef logic [GPR_W_DEF-1:0]  reg_index_t;
   typedef logic [DATA_W_DEF-1:0] word_t;

   typedef struct packed {
      reg_index_t gpr;
      word_t      data;
   } wb_entry_t;

   // Queue pointers carry one wrap bit above the index so full and empty are distinguishable.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/delayed_wb_arbiter_wb_entry_fifo.sv
// In-order queue of delayed writebacks, with every slot's key and a live-entry mask exported
// so the top can answer hazard queries against all pending writes.
module delayed_wb_arbiter_wb_entry_fifo
   import delayed_wb_arbiter_pkg::*;
#(
   parameter int  DEPTH = WB_DEPTH,
   parameter type T     = wb_entry_t,
   parameter int  KEY_W = GPR_W_DEF,
   localparam int PTR_W = ptr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  T                 din_i,
   input  logic             pop_i,
   output T                 head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [PTR_W-1:0] level_o,
   output logic [KEY_W-1:0] key_o [DEPTH],
   output logic [DEPTH-1:0] valid_o
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [PTR_W-1:0] wr_q, wr_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   T                 mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[PTR_W-1] != rd_q[PTR_W-1]) &&
                    (wr_q[IDX_W-1:0] == rd_q[IDX_W-1:0]);

   // No pass-through when full: a same-cycle pop does not make room for the push.
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   assign wr_d = wr_q + PTR_W'(do_push);
   assign rd_d = rd_q + PTR_W'(do_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_q[IDX_W-1:0]] <= din_i;
      end
   end

   assign head_o  = mem_q[rd_q[IDX_W-1:0]];
   assign level_o = wr_q - rd_q;

   // A slot is live when its distance from the read pointer is below the fill level.
   // The key is the entry's most significant field.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
         logic [IDX_W-1:0] offset;
         assign offset      = IDX_W'(gi) - rd_q[IDX_W-1:0];
         assign valid_o[gi] = ({1'b0, offset} < level_o);
         assign key_o[gi]   = mem_q[gi][$bits(T)-1 -: KEY_W];
      end
   endgenerate

   a_no_push_full : assert property (@(posedge clk) disable iff (reset) !(push_i && full_o));
   a_no_pop_empty : assert property (@(posedge clk) disable iff (reset) !(pop_i && empty_o));

endmodule

// File: rtl/delayed_wb_arbiter.sv
// Round-robin collector of delayed GPR writebacks feeding the spare GPR write port,
// with a pending-write hazard query and a drain indicator.
module delayed_wb_arbiter
   import delayed_wb_arbiter_pkg::*;
#(
   parameter int  N_SRC  = 2,
   parameter int  DEPTH  = WB_DEPTH,
   parameter int  DATA_W = DATA_W_DEF,
   parameter int  GPR_W  = GPR_W_DEF,
   localparam int LVL_W  = ptr_width(DEPTH)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_SRC-1:0]        src_valid_i,
   input  logic [N_SRC*GPR_W-1:0]  src_gpr_i,
   input  logic [N_SRC*DATA_W-1:0] src_data_i,
   output logic [N_SRC-1:0]        src_ready_o,
   input  logic                    wb_busy_i,
   output logic                    gpr_we_o,
   output logic [GPR_W-1:0]        gpr_waddr_o,
   output logic [DATA_W-1:0]       gpr_wdata_o,
   input  logic [GPR_W-1:0]        query_gpr_i,
   output logic                    query_hit_o,
   output logic [LVL_W-1:0]        level_o,
   output logic                    pipe_empty_o
);

   localparam int RR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   typedef struct packed {
      logic [GPR_W-1:0]  gpr;
      logic [DATA_W-1:0] data;
   } entry_t;

   logic [RR_W-1:0]  rr_q, rr_d;
   logic [N_SRC-1:0] grant;
   logic [RR_W-1:0]  grant_idx;
   logic             grant_any;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   entry_t           push_entry;
   entry_t           head;
   logic [GPR_W-1:0] entry_key [DEPTH];
   logic [DEPTH-1:0] entry_valid;

   function automatic int wrap_idx(input int base, input int off);
      return (base + off) % N_SRC;
   endfunction

   // Scan from the farthest candidate back to rr_q so the nearest requester wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         if (src_valid_i[wrap_idx(int'(rr_q), k)]) begin
            grant_any = 1'b1;
            grant_idx = RR_W'(wrap_idx(int'(rr_q), k));
         end
      end
      grant[grant_idx] = grant_any;
   end

   assign src_ready_o = grant & {N_SRC{~full & ~reset}};
   assign push        = grant_any & ~full & ~reset;
   assign push_entry  = {src_gpr_i[grant_idx*GPR_W +: GPR_W], src_data_i[grant_idx*DATA_W +: DATA_W]};

   assign rr_d = push ? RR_W'(wrap_idx(int'(grant_idx), 1)) : rr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_q <= '0;
      end else begin
         rr_q <= rr_d;
      end
   end

   delayed_wb_arbiter_wb_entry_fifo #(
      .DEPTH (DEPTH),
      .T     (entry_t),
      .KEY_W (GPR_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .din_i   (push_entry),
      .pop_i   (pop),
      .head_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level_o),
      .key_o   (entry_key),
      .valid_o (entry_valid)
   );

   // The spare port only steals cycles the regular writeback leaves idle.
   assign gpr_we_o    = ~empty & ~wb_busy_i & ~reset;
   assign pop         = gpr_we_o;
   assign gpr_waddr_o = head.gpr;
   assign gpr_wdata_o = head.data;

   always_comb begin
      query_hit_o = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
         if (entry_valid[j] && (entry_key[j] == query_gpr_i)) begin
            query_hit_o = 1'b1;
         end
      end
      for (int i = 0; i < N_SRC; i++) begin
         if (src_valid_i[i] && (src_gpr_i[i*GPR_W +: GPR_W] == query_gpr_i)) begin
            query_hit_o = 1'b1;
         end
      end
   end

   assign pipe_empty_o = empty & ~|src_valid_i;

   generate
      for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src_chk
         a_src_stable : assert property (@(posedge clk) disable iff (reset)
            (src_valid_i[gi] && !src_ready_o[gi]) |=>
               ($stable(src_gpr_i[gi*GPR_W +: GPR_W]) && $stable(src_data_i[gi*DATA_W +: DATA_W])));
      end
   endgenerate

endmodule

// File: tb/tb_delayed_wb_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a queue-based model.
module tb_delayed_wb_arbiter;

   localparam int N_SRC  = 2;
   localparam int DEPTH  = 4;
   localparam int DATA_W = 32;
   localparam int GPR_W  = 5;
   localparam int LVL_W  = $clog2(DEPTH) + 1;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [N_SRC-1:0]        src_valid_i;
   logic [N_SRC*GPR_W-1:0]  src_gpr_i;
   logic [N_SRC*DATA_W-1:0] src_data_i;
   logic [N_SRC-1:0]        src_ready_o;
   logic                    wb_busy_i;
   logic                    gpr_we_o;
   logic [GPR_W-1:0]        gpr_waddr_o;
   logic [DATA_W-1:0]       gpr_wdata_o;
   logic [GPR_W-1:0]        query_gpr_i;
   logic                    query_hit_o;
   logic [LVL_W-1:0]        level_o;
   logic                    pipe_empty_o;

   always #5 clk = ~clk;

   delayed_wb_arbiter #(
      .N_SRC(N_SRC), .DEPTH(DEPTH), .DATA_W(DATA_W), .GPR_W(GPR_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .src_valid_i  (src_valid_i),
      .src_gpr_i    (src_gpr_i),
      .src_data_i   (src_data_i),
      .src_ready_o  (src_ready_o),
      .wb_busy_i    (wb_busy_i),
      .gpr_we_o     (gpr_we_o),
      .gpr_waddr_o  (gpr_waddr_o),
      .gpr_wdata_o  (gpr_wdata_o),
      .query_gpr_i  (query_gpr_i),
      .query_hit_o  (query_hit_o),
      .level_o      (level_o),
      .pipe_empty_o (pipe_empty_o)
   );

   typedef struct {
      logic [GPR_W-1:0]  gpr;
      logic [DATA_W-1:0] data;
   } ent_t;

   // Reference model: pending writes in acceptance order and the next source to favour.
   ent_t q[$];
   int   rr;
   ent_t dut_log[$];

   logic              pv [N_SRC];
   logic [GPR_W-1:0]  pg [N_SRC];
   logic [DATA_W-1:0] pd [N_SRC];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic void drive();
      for (int i = 0; i < N_SRC; i++) begin
         src_valid_i[i]                   = pv[i];
         src_gpr_i[i*GPR_W +: GPR_W]      = pg[i];
         src_data_i[i*DATA_W +: DATA_W]   = pd[i];
      end
   endfunction

   // One clock cycle: apply inputs, compare all outputs with the model, then advance the model.
   task automatic step();
      int               g;
      logic             any_v;
      logic             hit;
      logic [N_SRC-1:0] exp_ready;
      logic             exp_we;
      drive();
      #4;
      exp_ready = '0;
      g = -1;
      if (!reset) begin
         for (int k = 0; k < N_SRC; k++) begin
            if (g < 0 && pv[(rr + k) % N_SRC]) g = (rr + k) % N_SRC;
         end
      end
      if (g >= 0 && q.size() < DEPTH) exp_ready[g] = 1'b1;
      exp_we = !reset && (q.size() > 0) && !wb_busy_i;
      any_v = 1'b0;
      hit   = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
         if (pv[i]) any_v = 1'b1;
         if (pv[i] && pg[i] == query_gpr_i) hit = 1'b1;
      end
      foreach (q[j]) if (q[j].gpr == query_gpr_i) hit = 1'b1;
      chk("src_ready", src_ready_o, exp_ready);
      chk("gpr_we", gpr_we_o, exp_we);
      if (exp_we) begin
         chk("gpr_waddr", gpr_waddr_o, q[0].gpr);
         chk("gpr_wdata", gpr_wdata_o, q[0].data);
      end
      chk("level", level_o, q.size());
      chk("query_hit", query_hit_o, hit);
      chk("pipe_empty", pipe_empty_o, (q.size() == 0) && !any_v);
      if (gpr_we_o === 1'b1) dut_log.push_back('{gpr_waddr_o, gpr_wdata_o});
      @(posedge clk);
      if (exp_we) void'(q.pop_front());
      if (exp_ready != '0) begin
         q.push_back('{pg[g], pd[g]});
         pv[g] = 1'b0;
         rr = (g + 1) % N_SRC;
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      q.delete();
      rr = 0;
      for (int i = 0; i < N_SRC; i++) pv[i] = 1'b0;
      step();
      reset = 1'b0;
   endtask

   initial begin
      int seq;
      int busy_left;
      reset       = 1'b1;
      wb_busy_i   = 1'b0;
      query_gpr_i = '0;
      rr          = 0;
      for (int i = 0; i < N_SRC; i++) begin
         pv[i] = 1'b0;
         pg[i] = '0;
         pd[i] = '0;
      end
      step();
      chk("rst_level", level_o, 0);
      reset = 1'b0;

      // 1: single push reaches the port the following cycle
      do_reset();
      pv[0] = 1'b1; pg[0] = 5'd3; pd[0] = 32'hDEADBEEF;
      step();
      chk("t1_we", gpr_we_o, 1);
      chk("t1_waddr", gpr_waddr_o, 3);
      chk("t1_wdata", gpr_wdata_o, 32'hDEADBEEF);
      step();
      chk("t1_level", level_o, 0);

      // 2: both sources contend, grants alternate
      do_reset();
      dut_log.delete();
      pv[0] = 1'b1; pg[0] = 5'd10; pd[0] = 32'hA0;
      pv[1] = 1'b1; pg[1] = 5'd20; pd[1] = 32'hB0;
      for (int n = 0; n < 4; n++) begin
         step();
         if (n < 3) begin
            if (!pv[0]) begin pv[0] = 1'b1; pg[0] = pg[0] + 5'd1; pd[0] = pd[0] + 32'd1; end
            if (!pv[1]) begin pv[1] = 1'b1; pg[1] = pg[1] + 5'd1; pd[1] = pd[1] + 32'd1; end
         end
      end
      pv[0] = 1'b0; pv[1] = 1'b0;
      for (int n = 0; n < 3; n++) step();
      begin
         logic [DATA_W-1:0] t2_exp [4];
         logic [DATA_W-1:0] got;
         t2_exp = '{32'hA0, 32'hB0, 32'hA1, 32'hB1};
         chk("t2_count", dut_log.size(), 4);
         for (int k = 0; k < 4; k++) begin
            got = (k < dut_log.size()) ? dut_log[k].data : '1;
            chk($sformatf("t2_order%0d", k), got, t2_exp[k]);
         end
      end

      // 3+4: port busy fills the queue, then a pop with a waiting source pops only
      do_reset();
      dut_log.delete();
      wb_busy_i = 1'b1;
      seq = 0;
      pv[0] = 1'b1; pg[0] = 5'(seq); pd[0] = 32'hC0 + seq;
      for (int n = 0; n < 10; n++) begin
         step();
         if (!pv[0]) begin seq++; pv[0] = 1'b1; pg[0] = 5'(seq); pd[0] = 32'hC0 + seq; end
      end
      chk("t3_level_full", level_o, 4);
      chk("t3_ready_blocked", src_ready_o, 0);
      wb_busy_i = 1'b0;
      step();
      chk("t4_level_after_pop", level_o, 3);
      chk("t4_ready_next", src_ready_o[0], 1);
      step();
      for (int n = 0; n < 5; n++) step();
      chk("t3_count", dut_log.size(), 5);
      for (int k = 0; k < 5; k++) begin
         logic [DATA_W-1:0] got;
         got = (k < dut_log.size()) ? dut_log[k].data : '1;
         chk($sformatf("t3_order%0d", k), got, 32'hC0 + k);
      end

      // 5: hazard query against queued and not-yet-accepted writes
      do_reset();
      wb_busy_i = 1'b1;
      pv[0] = 1'b1; pg[0] = 5'd7; pd[0] = 32'h77;
      query_gpr_i = 5'd7;
      step();
      chk("t5_hit_q7", query_hit_o, 1);
      query_gpr_i = 5'd8;
      #1;
      chk("t5_hit_q8_idle", query_hit_o, 0);
      pv[1] = 1'b1; pg[1] = 5'd8; pd[1] = 32'h88;
      drive();
      #1;
      chk("t5_hit_src8", query_hit_o, 1);
      step();
      query_gpr_i = 5'd7;
      wb_busy_i = 1'b0;
      drive();
      #1;
      chk("t5_hit_during_write", query_hit_o, 1);
      chk("t5_waddr", gpr_waddr_o, 7);
      step();
      chk("t5_hit_after_write", query_hit_o, 0);
      step();

      // 6: reset discards queued entries and the round-robin position
      do_reset();
      wb_busy_i = 1'b1;
      for (int n = 0; n < 3; n++) begin
         pv[0] = 1'b1; pg[0] = 5'(n + 1); pd[0] = 32'hE0 + n;
         step();
      end
      chk("t6_level_pre", level_o, 3);
      do_reset();
      chk("t6_level", level_o, 0);
      chk("t6_we", gpr_we_o, 0);
      chk("t6_pipe_empty", pipe_empty_o, 1);
      pv[0] = 1'b1; pg[0] = 5'd1; pd[0] = 32'h1;
      pv[1] = 1'b1; pg[1] = 5'd2; pd[1] = 32'h2;
      drive();
      #1;
      chk("t6_rr_zero", src_ready_o, 2'b01);
      step();
      step();

      // randomized traffic
      do_reset();
      wb_busy_i = 1'b0;
      busy_left = 0;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
            continue;
         end
         if (busy_left > 0) begin
            wb_busy_i = 1'b1;
            busy_left--;
         end else begin
            wb_busy_i = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 40) == 0) busy_left = $urandom_range(4, 12);
         end
         for (int i = 0; i < N_SRC; i++) begin
            if (!pv[i] && $urandom_range(0, 1) == 1) begin
               pv[i] = 1'b1;
               pg[i] = 5'($urandom_range(0, 15));
               pd[i] = $urandom;
            end
         end
         if (q.size() > 0 && $urandom_range(0, 1) == 1)
            query_gpr_i = q[$urandom_range(0, q.size() - 1)].gpr;
         else
            query_gpr_i = 5'($urandom_range(0, 15));
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
